dm_arbiter: RTL and testbench

Two-port arbiter sharing the single data memory (DM) between the pipeline's memory stage and a DMA requester. It muxes address, write data, write enable and byte enables onto the DM port and stalls the CPU when the DMA port wins. It bounds DMA starvation with a consecutive-grant counter and returns DMA read data registered. It sits between the M stage (after byte-enable generation) and the DM instance.

---
 rtl/dm_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dm_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//
// Purpose:
//   Shares the single data memory (DM) between the pipeline's M stage and a
//   DMA requester. The CPU normally has priority. A 4-bit consecutive-grant
//   counter bounds DMA starvation: after STARVE_LIMIT CPU grants while the DMA
//   request is pending, the DMA port wins one cycle and the CPU is stalled.
//   DMA read data is captured into a register and presented one cycle after
//   the acknowledge.
//
// Parameters:
//   STARVE_LIMIT  max consecutive CPU grants while Dma_Req is held (1..15)
//
// Ports:
//   Clk, Rst                         clock, asynchronous active-high reset
//   Cpu_Req/We/Addr/WData/BE         M-stage access (address and BE already
//                                    aligned by the requester)
//   Cpu_Stall                        CPU access not granted this cycle
//   Cpu_RData                        DM read data, passed straight through
//   Dma_Req/We/Addr/WData/BE         DMA access, held stable until Dma_Ack
//   Dma_Ack                          DMA access performed this cycle
//   Dma_RData, Dma_RValid            registered DMA read data, 1-cycle pulse
//   DM_Addr/WrData/WE/BE             to the DM instance
//   DM_RData                         combinational DM read data
//   Stall_Cnt                        CPU stall-cycle counter (only when the
//                                    DM_ARB_STATS_EN macro is defined)
//
// Build option:
//   DM_ARB_STATS_EN  adds the Stall_Cnt port and its 32-bit wrapping counter.
//                    Arbitration is identical with or without it.
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Cpu_Req,
  input  logic        Cpu_We,
  input  logic [31:0] Cpu_Addr,
  input  logic [31:0] Cpu_WData,
  input  logic [3:0]  Cpu_BE,
  output logic        Cpu_Stall,
  output logic [31:0] Cpu_RData,
  input  logic        Dma_Req,
  input  logic        Dma_We,
  input  logic [31:0] Dma_Addr,
  input  logic [31:0] Dma_WData,
  input  logic [3:0]  Dma_BE,
  output logic        Dma_Ack,
  output logic [31:0] Dma_RData,
  output logic        Dma_RValid,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_WrData,
  output logic        DM_WE,
  output logic [3:0]  DM_BE,
  input  logic [31:0] DM_RData
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0] Stall_Cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  cnt_q, cnt_d;
  logic        cpu_grant;
  logic        dma_grant;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        dma_rvalid_q, dma_rvalid_d;

  // Grant decision. The two grants are mutually exclusive: the CPU needs
  // cnt below the limit, while the DMA with a competing CPU request needs cnt
  // exactly at the limit. Without a DMA request cnt is held at zero, so the
  // CPU always wins when alone.
  always_comb begin
    cpu_grant = Cpu_Req && (cnt_q < LIMIT);
    dma_grant = Dma_Req && (!Cpu_Req || (cnt_q == LIMIT));
  end

  // DM port mux. An idle port is driven to all zeros so DM sees no stray
  // write and no leftover address from the previous owner.
  always_comb begin
    DM_Addr   = '0;
    DM_WrData = '0;
    DM_WE     = 1'b0;
    DM_BE     = '0;
    if (cpu_grant) begin
      DM_Addr   = Cpu_Addr;
      DM_WrData = Cpu_WData;
      DM_WE     = Cpu_We;
      DM_BE     = Cpu_BE;
    end else if (dma_grant) begin
      DM_Addr   = Dma_Addr;
      DM_WrData = Dma_WData;
      DM_WE     = Dma_We;
      DM_BE     = Dma_BE;
    end
  end

  // Requester-facing handshake. Cpu_RData is not gated: the pipeline only
  // consumes it in a cycle where Cpu_Stall is low.
  always_comb begin
    Cpu_Stall = Cpu_Req && !cpu_grant;
    Cpu_RData = DM_RData;
    Dma_Ack   = dma_grant;
  end

  // Starvation counter. It counts CPU grants only while the DMA is waiting
  // and clears when the DMA is served or withdraws. No saturation is needed:
  // reaching the limit forces a DMA grant, which clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!Dma_Req || dma_grant) begin
      cnt_d = '0;
    end else if (cpu_grant) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // DMA read capture. Data is taken from DM on the edge that closes a DMA
  // read grant and held afterwards, so the requester may sample it late.
  always_comb begin
    dma_rdata_d  = dma_rdata_q;
    dma_rvalid_d = 1'b0;
    if (dma_grant && !Dma_We) begin
      dma_rdata_d  = DM_RData;
      dma_rvalid_d = 1'b1;
    end
  end

  // State registers. Reset drops any read response in flight; the DMA
  // requester reissues its request afterwards.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q        <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign Dma_RData  = dma_rdata_q;
  assign Dma_RValid = dma_rvalid_q;

`ifdef DM_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall statistics: one count per edge on which the CPU is held off.
  // Wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Cpu_Stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
//
// Bench for dm_arbiter with STARVE_LIMIT=4 and a small byte-lane DM model.
// Each cycle is described by a vector of inputs and expected combinational
// outputs. Expected DMA read data is queued when a DMA read acknowledge is
// expected and popped when the DUT raises Dma_RValid. When DM_ARB_STATS_EN is
// defined the stall counter is also compared against a running model.
// ---------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_be;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
`ifdef DM_ARB_STATS_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct {
    string       name;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_be;
    logic        exp_stall;
    logic        exp_ack;
    logic        exp_dm_we;
    logic [31:0] exp_dm_addr;
    logic [31:0] exp_dm_wdata;
    logic [3:0]  exp_dm_be;
    logic        chk_cpu_rdata;
    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_dma_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks;
  int          errors;
  int          stall_model;
  logic [31:0] mem [0:63];

  dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .Cpu_Req    (cpu_req),
    .Cpu_We     (cpu_we),
    .Cpu_Addr   (cpu_addr),
    .Cpu_WData  (cpu_wdata),
    .Cpu_BE     (cpu_be),
    .Cpu_Stall  (cpu_stall),
    .Cpu_RData  (cpu_rdata),
    .Dma_Req    (dma_req),
    .Dma_We     (dma_we),
    .Dma_Addr   (dma_addr),
    .Dma_WData  (dma_wdata),
    .Dma_BE     (dma_be),
    .Dma_Ack    (dma_ack),
    .Dma_RData  (dma_rdata),
    .Dma_RValid (dma_rvalid),
    .DM_Addr    (dm_addr),
    .DM_WrData  (dm_wdata),
    .DM_WE      (dm_we),
    .DM_BE      (dm_be),
    .DM_RData   (dm_rdata)
`ifdef DM_ARB_STATS_EN
    ,
    .Stall_Cnt  (stall_cnt)
`endif
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory model: combinational read, byte-lane write on the rising edge
  assign dm_rdata = mem[dm_addr[7:2]];

  always @(posedge clk) begin
    if (dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_be[b]) mem[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
  end

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string n,
    input logic cr, input logic cw, input logic [31:0] ca,
    input logic [31:0] cd, input logic [3:0] cb,
    input logic dr, input logic dw, input logic [31:0] da,
    input logic [31:0] dd, input logic [3:0] db,
    input logic es, input logic ea, input logic ew,
    input logic [31:0] eaddr, input logic [31:0] ewd, input logic [3:0] ebe,
    input logic chk, input logic [31:0] ecr, input logic [31:0] edr);
    vec_t v;
    v.name = n;
    v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
    v.cpu_be = cb;
    v.dma_req = dr; v.dma_we = dw; v.dma_addr = da; v.dma_wdata = dd;
    v.dma_be = db;
    v.exp_stall = es; v.exp_ack = ea; v.exp_dm_we = ew;
    v.exp_dm_addr = eaddr; v.exp_dm_wdata = ewd; v.exp_dm_be = ebe;
    v.chk_cpu_rdata = chk; v.exp_cpu_rdata = ecr; v.exp_dma_rdata = edr;
    return v;
  endfunction

  // One clock cycle: drive after the edge, check combinational outputs on the
  // falling edge, then check registered outputs just after the next edge.
  // rst_mid asserts reset between those two points.
  task automatic apply_stimulus(input vec_t v, input bit rst_mid);
    bit push;
    cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr;
    cpu_wdata = v.cpu_wdata; cpu_be = v.cpu_be;
    dma_req = v.dma_req; dma_we = v.dma_we; dma_addr = v.dma_addr;
    dma_wdata = v.dma_wdata; dma_be = v.dma_be;
    @(negedge clk);
    check_output({v.name, "/stall"}, 32'(cpu_stall), 32'(v.exp_stall));
    check_output({v.name, "/ack"}, 32'(dma_ack), 32'(v.exp_ack));
    check_output({v.name, "/dm_we"}, 32'(dm_we), 32'(v.exp_dm_we));
    check_output({v.name, "/dm_addr"}, dm_addr, v.exp_dm_addr);
    check_output({v.name, "/dm_wdata"}, dm_wdata, v.exp_dm_wdata);
    check_output({v.name, "/dm_be"}, 32'(dm_be), 32'(v.exp_dm_be));
    if (v.chk_cpu_rdata) begin
      check_output({v.name, "/cpu_rdata"}, cpu_rdata, v.exp_cpu_rdata);
    end
    push = v.exp_ack && !v.dma_we && !rst_mid;
    if (push) exp_q.push_back(v.exp_dma_rdata);
    if (v.exp_stall) stall_model++;
    if (rst_mid) begin
      rst = 1'b1;
      stall_model = 0;
    end
    @(posedge clk);
    #1;
    check_output({v.name, "/rvalid"}, 32'(dma_rvalid), 32'(push));
    if (dma_rvalid) begin
      if (exp_q.size() == 0) begin
        check_output({v.name, "/sb_underflow"}, 32'd1, 32'd0);
      end else begin
        check_output({v.name, "/dma_rdata"}, dma_rdata, exp_q.pop_front());
      end
    end else if (push && exp_q.size() != 0) begin
      void'(exp_q.pop_back());
    end
    if (rst_mid) begin
      check_output({v.name, "/rdata_rst"}, dma_rdata, 32'd0);
    end
`ifdef DM_ARB_STATS_EN
    check_output({v.name, "/stall_cnt"}, stall_cnt, 32'(stall_model));
`endif
    if (rst_mid) rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stall_model = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset with both requesters active: CPU keeps priority, nothing pending
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
    cpu_be = 4'hF;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h14; dma_wdata = '0;
    dma_be = 4'hF;
    @(negedge clk);
    check_output("rst/stall", 32'(cpu_stall), 32'd0);
    check_output("rst/ack", 32'(dma_ack), 32'd0);
    check_output("rst/dm_addr", dm_addr, 32'h10);
    @(posedge clk);
    #1;
    check_output("rst/rvalid", 32'(dma_rvalid), 32'd0);
    check_output("rst/dma_rdata", dma_rdata, 32'd0);
`ifdef DM_ARB_STATS_EN
    check_output("rst/stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;

    // Single-cycle vectors, including a starvation run at LIMIT=4
    vecs.push_back(mk("idle", 0,0,0,0,0, 0,0,0,0,0,
                      0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk("cpu_store", 1,1,32'h10,32'h12345678,4'hF, 0,0,0,0,0,
                      0,0,1,32'h10,32'h12345678,4'hF, 0,0,0));
    vecs.push_back(mk("cpu_load", 1,0,32'h10,0,4'hF, 0,0,0,0,0,
                      0,0,0,32'h10,0,4'hF, 1,32'h12345678,0));
    vecs.push_back(mk("dma_read", 0,0,0,0,0, 1,0,32'h10,0,4'hF,
                      0,1,0,32'h10,0,4'hF, 1,32'h12345678,32'h12345678));
    vecs.push_back(mk("idle2", 0,0,0,0,0, 0,0,0,0,0,
                      0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk("dma_wbyte", 0,0,0,0,0, 1,1,32'h14,32'hAABBCCDD,4'b0100,
                      0,1,1,32'h14,32'hAABBCCDD,4'b0100, 0,0,0));
    vecs.push_back(mk("cpu_lbyte", 1,0,32'h14,0,4'hF, 0,0,0,0,0,
                      0,0,0,32'h14,0,4'hF, 1,32'h00BB0000,0));
    for (int k = 0; k < LIMIT; k++) begin
      vecs.push_back(mk($sformatf("starve_cpu%0d", k),
                        1,0,32'h10,0,4'hF, 1,0,32'h14,0,4'hF,
                        0,0,0,32'h10,0,4'hF, 1,32'h12345678,0));
    end
    vecs.push_back(mk("starve_dma", 1,0,32'h10,0,4'hF, 1,0,32'h14,0,4'hF,
                      1,1,0,32'h14,0,4'hF, 1,32'h00BB0000,32'h00BB0000));
    vecs.push_back(mk("cpu_after", 1,0,32'h10,0,4'hF, 0,0,0,0,0,
                      0,0,0,32'h10,0,4'hF, 1,32'h12345678,0));

    foreach (vecs[i]) apply_stimulus(vecs[i], 1'b0);

    // Same-address conflict: DMA write forced in by the limit, CPU retry
    // then sees the new data
    for (int k = 0; k <= LIMIT + 1; k++) begin
      if (k < LIMIT) begin
        apply_stimulus(mk($sformatf("conf_cpu%0d", k),
                          1,0,32'h20,0,4'hF, 1,1,32'h20,32'hDEADBEEF,4'hF,
                          0,0,0,32'h20,0,4'hF, 1,32'h0,0), 1'b0);
      end else if (k == LIMIT) begin
        apply_stimulus(mk("conf_dma",
                          1,0,32'h20,0,4'hF, 1,1,32'h20,32'hDEADBEEF,4'hF,
                          1,1,1,32'h20,32'hDEADBEEF,4'hF, 0,0,0), 1'b0);
      end else begin
        apply_stimulus(mk("conf_retry",
                          1,0,32'h20,0,4'hF, 0,0,0,0,0,
                          0,0,0,32'h20,0,4'hF, 1,32'hDEADBEEF,0), 1'b0);
      end
    end

    // Clean reset, then ten back-to-back forced DMA reads
    rst = 1'b1;
    stall_model = 0;
    @(posedge clk);
    #1;
    check_output("rst2/rvalid", 32'(dma_rvalid), 32'd0);
    check_output("rst2/dma_rdata", dma_rdata, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10 * (LIMIT + 1); k++) begin
      if ((k % (LIMIT + 1)) == LIMIT) begin
        apply_stimulus(mk($sformatf("b2b_dma%0d", k),
                          1,0,32'h10,0,4'hF, 1,0,32'h20,0,4'hF,
                          1,1,0,32'h20,0,4'hF, 1,32'hDEADBEEF,32'hDEADBEEF),
                       1'b0);
      end else begin
        apply_stimulus(mk($sformatf("b2b_cpu%0d", k),
                          1,0,32'h10,0,4'hF, 1,0,32'h20,0,4'hF,
                          0,0,0,32'h10,0,4'hF, 1,32'h12345678,0), 1'b0);
      end
    end
`ifdef DM_ARB_STATS_EN
    check_output("b2b/stall_cnt10", stall_cnt, 32'd10);
`endif

    // Reset arrives in a DMA read grant cycle: response dropped, counter
    // cleared, reissued request waits a full LIMIT again
    for (int k = 0; k < 2 * (LIMIT + 1); k++) begin
      if ((k % (LIMIT + 1)) == LIMIT) begin
        apply_stimulus(mk($sformatf("rmid_dma%0d", k),
                          1,0,32'h10,0,4'hF, 1,0,32'h20,0,4'hF,
                          1,1,0,32'h20,0,4'hF, 1,32'hDEADBEEF,32'hDEADBEEF),
                       (k == LIMIT) ? 1'b1 : 1'b0);
      end else begin
        apply_stimulus(mk($sformatf("rmid_cpu%0d", k),
                          1,0,32'h10,0,4'hF, 1,0,32'h20,0,4'hF,
                          0,0,0,32'h10,0,4'hF, 1,32'h12345678,0), 1'b0);
      end
    end

    apply_stimulus(mk("idle_end", 0,0,0,0,0, 0,0,0,0,0,
                      0,0,0,0,0,0, 0,0,0), 1'b0);
    check_output("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
